// File: rtl/correlation_vacc.sv
// correlation_vacc: per-channel integrator for |x1|^2, |x2|^2 and the complex
// cross-correlation. Running sums live in a 1R/1W RAM indexed by channel and
// are updated by a two-stage read-modify-write pipeline. One vector is emitted
// per accumulation period.
module correlation_vacc #(
    parameter int unsigned DIN_WIDTH  = 18,
    parameter int unsigned VECTOR_LEN = 512,
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned DOUT_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2*DIN_WIDTH:0]          din1_pow,
    input  logic [2*DIN_WIDTH:0]          din2_pow,
    input  logic [2*DIN_WIDTH:0]          corr_re,
    input  logic [2*DIN_WIDTH:0]          corr_im,
    input  logic                          din_valid,
    input  logic [ACC_WIDTH-1:0]          acc_len,
    output logic [DOUT_WIDTH-1:0]         pow1_acc,
    output logic [DOUT_WIDTH-1:0]         pow2_acc,
    output logic [DOUT_WIDTH-1:0]         corr_re_acc,
    output logic [DOUT_WIDTH-1:0]         corr_im_acc,
    output logic [$clog2(VECTOR_LEN)-1:0] dout_chan,
    output logic                          dout_valid,
    output logic                          dout_last
);

    localparam int unsigned CW = $clog2(VECTOR_LEN);

    // One RAM word: the four running sums of a channel.
    typedef struct packed {
        logic [DOUT_WIDTH-1:0] p1;
        logic [DOUT_WIDTH-1:0] p2;
        logic [DOUT_WIDTH-1:0] re;
        logic [DOUT_WIDTH-1:0] im;
    } lanes_t;

    logic [CW-1:0]        chan_cnt;
    logic [ACC_WIDTH-1:0] frame_cnt;
    logic [ACC_WIDTH-1:0] acc_len_q;

    logic                 start_c;
    logic [ACC_WIDTH-1:0] len_eff_c;
    logic                 last_frame_c;
    logic                 chan_wrap_c;
    lanes_t               din_ext_c;

    lanes_t               mem [VECTOR_LEN];
    lanes_t               ram_q;

    logic                 s1_valid;
    logic                 s1_first;
    logic                 s1_last;
    logic [CW-1:0]        s1_chan;
    lanes_t               s1_din;
    lanes_t               sum_c;

    // Integration bookkeeping; acc_len is taken live on the first sample of an integration.
    always_comb begin
        start_c      = (chan_cnt == '0) && (frame_cnt == '0);
        len_eff_c    = acc_len_q;
        if (start_c) begin
            len_eff_c = (acc_len == '0) ? ACC_WIDTH'(1) : acc_len;
        end
        last_frame_c = (frame_cnt == ACC_WIDTH'(len_eff_c - ACC_WIDTH'(1)));
        chan_wrap_c  = (chan_cnt == CW'(VECTOR_LEN - 1));
    end

    // Extend inputs to accumulator width: powers unsigned, correlation signed.
    always_comb begin
        din_ext_c.p1 = DOUT_WIDTH'(din1_pow);
        din_ext_c.p2 = DOUT_WIDTH'(din2_pow);
        din_ext_c.re = DOUT_WIDTH'($signed(corr_re));
        din_ext_c.im = DOUT_WIDTH'($signed(corr_im));
    end

    // Channel/frame counters, advanced only by valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            chan_cnt  <= '0;
            frame_cnt <= '0;
            acc_len_q <= '0;
        end else if (din_valid) begin
            if (start_c) begin
                acc_len_q <= len_eff_c;
            end
            chan_cnt <= CW'(chan_cnt + 1'b1);
            if (chan_wrap_c) begin
                frame_cnt <= last_frame_c ? '0 : ACC_WIDTH'(frame_cnt + 1'b1);
            end
        end
    end

    // Stage 1: capture the sample and its flags alongside the RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_chan  <= '0;
            s1_din   <= '0;
        end else begin
            s1_valid <= din_valid;
            if (din_valid) begin
                s1_first <= (frame_cnt == '0);
                s1_last  <= last_frame_c;
                s1_chan  <= chan_cnt;
                s1_din   <= din_ext_c;
            end
        end
    end

    // Stage 2 adder; the stored sum is ignored on the first frame so the RAM never needs clearing.
    always_comb begin
        lanes_t base;
        base     = s1_first ? '0 : ram_q;
        sum_c.p1 = base.p1 + s1_din.p1;
        sum_c.p2 = base.p2 + s1_din.p2;
        sum_c.re = base.re + s1_din.re;
        sum_c.im = base.im + s1_din.im;
    end

    // Accumulator RAM: read at the incoming channel, write back all but the final frame.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            ram_q <= mem[chan_cnt];
        end
        if (s1_valid && !s1_last) begin
            mem[s1_chan] <= sum_c;
        end
    end

    // Output register: presents the finished sum of each channel for one cycle, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            pow1_acc    <= '0;
            pow2_acc    <= '0;
            corr_re_acc <= '0;
            corr_im_acc <= '0;
            dout_chan   <= '0;
            dout_valid  <= 1'b0;
            dout_last   <= 1'b0;
        end else begin
            dout_valid <= s1_valid && s1_last;
            dout_last  <= s1_valid && s1_last && (s1_chan == CW'(VECTOR_LEN - 1));
            if (s1_valid && s1_last) begin
                pow1_acc    <= sum_c.p1;
                pow2_acc    <= sum_c.p2;
                corr_re_acc <= sum_c.re;
                corr_im_acc <= sum_c.im;
                dout_chan   <= s1_chan;
            end
        end
    end

endmodule
